// File: rtl/mul_scheduler.sv
// Round-robin front end that lets two requesters share one multi-cycle Booth multiplier.
// Optional BUSY watchdog enabled by defining MUL_SCHED_TIMEOUT_EN.
module mul_scheduler #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_m,
  input  logic [WIDTH-1:0]   req0_q,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_m,
  input  logic [WIDTH-1:0]   req1_q,
  output logic [WIDTH-1:0]   mul_m,
  output logic [WIDTH-1:0]   mul_q,
  output logic               mul_start,
  input  logic [2*WIDTH-1:0] mul_out,
  input  logic               mul_done,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_id,
  output logic [2*WIDTH-1:0] res_data,
  output logic               res_err,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic   last_grant;
  logic   grant;
  logic   accept;
  logic   armed;
  logic   done_ok;
  logic   timeout_hit;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mul_scheduler: TIMEOUT must be at least 1");
  end

  // Alternate on contention; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = req1_valid;
    end
  end

  assign accept     = (state == IDLE) && (req0_valid || req1_valid) && !rst;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  // armed is low for the first BUSY cycle, masking a done left over from earlier.
  assign done_ok = (state == BUSY) && armed && mul_done;

`ifdef MUL_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == START) begin
      tmo_cnt <= '0;
    end else if (state == BUSY) begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  assign timeout_hit = (state == BUSY) && !done_ok && (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_err <= 1'b0;
    end else if (accept) begin
      res_err <= 1'b0;
    end else if (timeout_hit) begin
      res_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign res_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    res_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START;
        end
      end
      START: begin
        mul_start = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (done_ok || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand and result registers; last_grant resets to 1 so port 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      mul_m      <= '0;
      mul_q      <= '0;
      res_id     <= 1'b0;
      res_data   <= '0;
      armed      <= 1'b0;
    end else begin
      armed <= (state == BUSY);
      if (accept) begin
        mul_m      <= grant ? req1_m : req0_m;
        mul_q      <= grant ? req1_q : req0_q;
        last_grant <= grant;
        res_id     <= grant;
      end
      if (done_ok) begin
        res_data <= mul_out;
      end else if (timeout_hit) begin
        res_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mul_scheduler.sv
// Bench for mul_scheduler: behavioural multiplier stub, directed table, corner sequences
// and a randomized two-port run checked against a queue-based scoreboard.
module tb_mul_scheduler;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [WIDTH-1:0]  req0_m, req0_q, req1_m, req1_q;
  logic [WIDTH-1:0]  mul_m, mul_q;
  logic              mul_start;
  logic [2*WIDTH-1:0] mul_out;
  logic              mul_done;
  logic              res_valid, res_ready, res_id, res_err, busy;
  logic [2*WIDTH-1:0] res_data;

  int n_vec = 0;
  int n_err = 0;

  mul_scheduler #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_m(req0_m), .req0_q(req0_q),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_m(req1_m), .req1_q(req1_q),
    .mul_m(mul_m), .mul_q(mul_q), .mul_start(mul_start),
    .mul_out(mul_out), .mul_done(mul_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  // Multiplier stub: mode 0 normal, 1 never finishes, 2 holds done high outside real work.
  int          stub_mode = 0;
  int          stub_lat  = 2;
  logic        stub_active;
  int          stub_cnt;
  logic [63:0] stub_prod;
  logic        real_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_active <= 1'b0;
      stub_cnt    <= 0;
      stub_prod   <= '0;
    end else if (mul_start) begin
      stub_active <= 1'b1;
      stub_cnt    <= 1;
      stub_prod   <= smul(mul_m, mul_q);
    end else if (stub_active) begin
      if (stub_cnt == stub_lat) stub_active <= 1'b0;
      else stub_cnt <= stub_cnt + 1;
    end
  end

  assign real_done = stub_active && (stub_cnt == stub_lat) && (stub_mode != 1);
  assign mul_done  = real_done || ((stub_mode == 2) && (!stub_active || stub_cnt < 2));
  assign mul_out   = real_done ? stub_prod : 64'hBAD0_BAD0_BAD0_BAD0;

  int start_cnt = 0;
  always @(negedge clk) begin
    if (mul_start) start_cnt <= start_cnt + 1;
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request and hold it until the scheduler takes it.
  task automatic applyStimulus(input bit port, input logic [31:0] m, input logic [31:0] q);
    bit got;
    got = 1'b0;
    @(negedge clk);
    if (port) begin
      req1_valid = 1'b1; req1_m = m; req1_q = q;
    end else begin
      req0_valid = 1'b1; req0_m = m; req0_q = q;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (port ? req1_ready : req0_ready) got = 1'b1;
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checkOutput("request accepted", got, 1'b1);
  endtask

  // Wait for a result, report BUSY-cycle count, then consume it.
  task automatic awaitResult(output bit id, output logic [63:0] data, output bit err,
                             output bit ok, output int cyc);
    ok = 1'b0; id = 1'b0; data = '0; err = 1'b0; cyc = -1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (res_valid) begin
        ok = 1'b1; id = res_id; data = res_data; err = res_err; cyc = i;
      end
    end
    if (ok) begin
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  typedef struct {
    bit          port;
    logic [31:0] m;
    logic [31:0] q;
    int          lat;
    int          mode;
    logic [63:0] exp;
  } vec_t;

  typedef struct { logic [31:0] m; logic [31:0] q; } op_t;
  typedef struct { bit id; logic [63:0] p; } res_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  bit          rid, rerr, ok, seen, a0, a1, first_set, first_acc, lg, eid, gid;
  logic [63:0] rdata;
  int          cyc, s0, nres;
  bit          rid_a[2];
  logic [63:0] rd_a[2];
  op_t         q0[$];
  op_t         q1[$];
  res_t        expq[$];
  op_t         op;
  res_t        er;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 32'd2,          32'd3,          2, 0, 64'd6};
    vecs[1] = '{1'b1, 32'h7FFF_FFFF,  32'd2,          3, 0, 64'h0000_0000_FFFF_FFFE};
    vecs[2] = '{1'b0, 32'hFFFF_FFFB,  32'd7,          4, 0, 64'hFFFF_FFFF_FFFF_FFDD};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  2, 0, 64'd1};
    vecs[4] = '{1'b0, 32'h8000_0000,  32'h8000_0000,  5, 0, 64'h4000_0000_0000_0000};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'd1,          2, 0, 64'hFFFF_FFFF_8000_0000};
    vecs[6] = '{1'b0, 32'd6,          32'd7,          2, 2, 64'd42};
    vecs[7] = '{1'b1, 32'h0001_0000,  32'h0001_0000,  3, 2, 64'h0000_0001_0000_0000};
    vecs[8] = '{1'b0, 32'd0,          32'hFFFF_FFFF,  6, 0, 64'd0};

    // Reset state, with a valid request pending to prove ready is held off.
    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b1; req0_m = 32'd5; req0_q = 32'd5;
    req1_valid = 1'b0; req1_m = '0; req1_q = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset outputs",
                {busy, res_valid, res_err, mul_start, req0_ready, req1_ready, res_id, res_data, mul_m, mul_q},
                '0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Both valid at once after reset: port 0 first, then port 1.
    res_ready = 1'b1; stub_mode = 0; stub_lat = 2;
    @(negedge clk);
    req0_valid = 1'b1; req0_m = 32'hFFFF_FFFB; req0_q = 32'd7;
    req1_valid = 1'b1; req1_m = 32'd4;         req1_q = 32'd4;
    nres = 0; first_set = 1'b0; first_acc = 1'b0;
    rid_a[0] = 1'b0; rid_a[1] = 1'b0; rd_a[0] = '0; rd_a[1] = '0;
    for (int c = 0; c < 100 && nres < 2; c++) begin
      #1;
      a0 = req0_ready; a1 = req1_ready;
      if ((a0 || a1) && !first_set) begin
        first_set = 1'b1; first_acc = a1;
      end
      if (res_valid) begin
        rid_a[nres] = res_id; rd_a[nres] = res_data; nres++;
      end
      @(negedge clk);
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    checkOutput("both-valid first grant", {first_set, first_acc}, 2'b10);
    checkOutput("both-valid result count", nres, 2);
    checkOutput("both-valid result 0", {rid_a[0], rd_a[0]}, {1'b0, 64'hFFFF_FFFF_FFFF_FFDD});
    checkOutput("both-valid result 1", {rid_a[1], rd_a[1]}, {1'b1, 64'd16});

    // Directed table: product, owner, latency and a single start pulse per request.
    for (int i = 0; i < NV; i++) begin
      stub_mode = vecs[i].mode;
      stub_lat  = vecs[i].lat;
      s0 = start_cnt;
      applyStimulus(vecs[i].port, vecs[i].m, vecs[i].q);
      awaitResult(rid, rdata, rerr, ok, cyc);
      checkOutput($sformatf("vec%0d result", i), {ok, rid, rerr, rdata}, {1'b1, vecs[i].port, 1'b0, vecs[i].exp});
      checkOutput($sformatf("vec%0d latency", i), cyc, vecs[i].lat);
      checkOutput($sformatf("vec%0d start pulses", i), start_cnt - s0, 1);
    end
    stub_mode = 0;

    // Backpressure: result held for 10 cycles while port 1 waits.
    stub_lat = 3;
    applyStimulus(1'b0, 32'd9, 32'd9);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (res_valid) seen = 1'b1;
    end
    checkOutput("hold result appeared", seen, 1'b1);
    req1_valid = 1'b1; req1_m = 32'd3; req1_q = 32'hFFFF_FFFD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("hold cycle %0d", i),
                  {res_valid, res_id, res_data, req0_ready, req1_ready},
                  {1'b1, 1'b0, 64'd81, 1'b0, 1'b0});
    end
    res_ready = 1'b1;
    checkOutput("no accept during result handshake", req1_ready, 1'b0);
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    checkOutput("waiting port accepted after result", req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    awaitResult(rid, rdata, rerr, ok, cyc);
    checkOutput("waiting port result", {ok, rid, rerr, rdata}, {1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF7});

    // Reset in BUSY: nothing from the aborted op, next request served normally.
    stub_lat = 12;
    applyStimulus(1'b0, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("busy before abort", busy, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("abort reset outputs",
                {busy, res_valid, res_err, mul_start, req0_ready, req1_ready, res_id, res_data, mul_m, mul_q},
                '0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (res_valid) seen = 1'b1;
    end
    checkOutput("no result after abort", seen, 1'b0);
    stub_lat = 2;
    applyStimulus(1'b1, 32'h7FFF_FFFF, 32'd2);
    awaitResult(rid, rdata, rerr, ok, cyc);
    checkOutput("post-abort result", {ok, rid, rerr, rdata}, {1'b1, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFE});

    // Multiplier that never completes.
    stub_mode = 1;
    applyStimulus(1'b0, 32'd11, 32'd13);
`ifdef MUL_SCHED_TIMEOUT_EN
    awaitResult(rid, rdata, rerr, ok, cyc);
    checkOutput("timeout result", {ok, rid, rerr, rdata}, {1'b1, 1'b0, 1'b1, 64'd0});
    checkOutput("timeout latency", cyc, TIMEOUT);
`else
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 30; i++) begin
      @(negedge clk);
      #1;
      if (res_valid || res_err) seen = 1'b1;
    end
    checkOutput("no timeout without watchdog", {seen, busy}, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    stub_mode = 0;

    // Randomized two-port traffic against a scoreboard; model starts from reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lg = 1'b1;
    for (int c = 0; c < 3500; c++) begin
      @(negedge clk);
      if (c < 2500 && $urandom_range(0, 3) == 0 && q0.size() < 4) q0.push_back('{$urandom, $urandom});
      if (c < 2500 && $urandom_range(0, 3) == 0 && q1.size() < 4) q1.push_back('{$urandom, $urandom});
      req0_valid = (q0.size() > 0);
      if (req0_valid) begin req0_m = q0[0].m; req0_q = q0[0].q; end
      req1_valid = (q1.size() > 0);
      if (req1_valid) begin req1_m = q1[0].m; req1_q = q1[0].q; end
      res_ready = ($urandom_range(0, 2) != 0);
      if (!stub_active) stub_lat = $urandom_range(2, 6);
      #1;
      if (req0_ready || req1_ready) begin
        eid = (req0_valid && req1_valid) ? ~lg : req1_valid;
        gid = req1_ready;
        checkOutput("random grant", {req0_ready, req1_ready}, eid ? 2'b01 : 2'b10);
        op = gid ? q1.pop_front() : q0.pop_front();
        expq.push_back('{gid, smul(op.m, op.q)});
        lg = gid;
      end
      if (res_valid && res_ready) begin
        if (expq.size() == 0) begin
          checkOutput("random unexpected result", 1'b1, 1'b0);
        end else begin
          er = expq.pop_front();
          checkOutput("random result", {res_id, res_err, res_data}, {er.id, 1'b0, er.p});
        end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    checkOutput("random drained", {q0.size(), q1.size(), expq.size()}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
